// File: rtl/eth_mii_frame_rx.sv
// MII receive path: preamble/SFD detection, byte assembly, header capture,
// FCS/length/alignment checks and running good/bad frame counters.
//
// state | meaning
// IDLE  | waiting for the first preamble nibble
// PRE   | counting 0x5 preamble nibbles, looking for SFD 0xD
// DATA  | post-SFD nibbles: byte assembly, CRC, header capture
// END   | single cycle: publish status, pulse frame_done, bump counters
// DROP  | malformed start, discard until rx_en falls
module eth_mii_frame_rx #(
    parameter int PREAMBLE_MIN = 8,
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_rx_ce,
    input  logic        io_rx_en,
    input  logic [3:0]  io_rx_data,
    output logic        io_byte_valid,
    output logic [7:0]  io_byte,
    output logic        io_frame_done,
    output logic        io_frame_ok,
    output logic        io_crc_err,
    output logic        io_len_err,
    output logic        io_align_err,
    output logic [15:0] io_frame_len,
    output logic [47:0] io_da,
    output logic [47:0] io_sa,
    output logic [15:0] io_etype,
    input  logic        io_cnt_clr,
    output logic [47:0] io_good_count,
    output logic [31:0] io_bad_count
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [3:0]  PRE_MIN     = 4'(PREAMBLE_MIN);
    localparam logic [15:0] LEN_MIN     = 16'(MIN_LEN);
    localparam logic [15:0] LEN_MAX     = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_END,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]  r_pcnt;
    logic [31:0] r_crc;
    logic [3:0]  r_low;
    logic        r_half;
    logic [15:0] r_byte_cnt;
    logic [47:0] r_da_sh;
    logic [47:0] r_sa_sh;
    logic [15:0] r_et_sh;

    logic        r_byte_valid;
    logic [7:0]  r_byte;
    logic        r_done;
    logic        r_ok;
    logic        r_crc_err;
    logic        r_len_err;
    logic        r_align_err;
    logic [15:0] r_len;
    logic [47:0] r_da;
    logic [47:0] r_sa;
    logic [15:0] r_etype;
    logic [47:0] r_good_cnt;
    logic [31:0] r_bad_cnt;

    logic        w_data_nib;
    logic        w_sfd_hit;
    logic [31:0] w_crc_next;
    logic        w_crc_err;
    logic        w_len_err;
    logic        w_align_err;
    logic        w_ok;

    // Reflected CRC-32 advanced by one nibble, LSB first.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] v;
        v = c ^ {28'd0, d};
        for (int k = 0; k < 4; k++) begin
            v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
        end
        return v;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_rx_ce && io_rx_en) begin
                    w_next = (io_rx_data == 4'h5) ? S_PRE : S_DROP;
                end
            end
            S_PRE: begin
                if (io_rx_ce) begin
                    if (!io_rx_en) begin
                        w_next = S_IDLE;
                    end else if (io_rx_data == 4'h5) begin
                        w_next = S_PRE;
                    end else if (io_rx_data == 4'hD && r_pcnt >= PRE_MIN) begin
                        w_next = S_DATA;
                    end else begin
                        w_next = S_DROP;
                    end
                end
            end
            S_DATA: begin
                if (io_rx_ce && !io_rx_en) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                w_next = S_IDLE;
            end
            S_DROP: begin
                if (io_rx_ce && !io_rx_en) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_data_nib  = io_rx_ce && io_rx_en && (r_state == S_DATA);
    assign w_sfd_hit   = (r_state == S_PRE) && (w_next == S_DATA);
    assign w_crc_next  = crc_nib(r_crc, io_rx_data);
    assign w_crc_err   = (r_crc != CRC_RESIDUE);
    assign w_len_err   = (r_byte_cnt < LEN_MIN) || (r_byte_cnt > LEN_MAX);
    assign w_align_err = r_half;
    assign w_ok        = !(w_crc_err || w_len_err || w_align_err);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt       <= '0;
            r_crc        <= CRC_INIT;
            r_low        <= '0;
            r_half       <= 1'b0;
            r_byte_cnt   <= '0;
            r_da_sh      <= '0;
            r_sa_sh      <= '0;
            r_et_sh      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            if (io_rx_ce && io_rx_en && io_rx_data == 4'h5) begin
                if (r_state == S_IDLE) begin
                    r_pcnt <= 4'd1;
                end else if (r_state == S_PRE && r_pcnt != 4'hF) begin
                    r_pcnt <= r_pcnt + 4'd1;
                end
            end
            if (w_sfd_hit) begin
                r_crc      <= CRC_INIT;
                r_half     <= 1'b0;
                r_byte_cnt <= '0;
                r_da_sh    <= '0;
                r_sa_sh    <= '0;
                r_et_sh    <= '0;
            end
            if (w_data_nib) begin
                r_crc <= w_crc_next;
                if (!r_half) begin
                    r_low  <= io_rx_data;
                    r_half <= 1'b1;
                end else begin
                    r_half       <= 1'b0;
                    r_byte       <= {io_rx_data, r_low};
                    r_byte_valid <= 1'b1;
                    if (r_byte_cnt != 16'hFFFF) begin
                        r_byte_cnt <= r_byte_cnt + 16'd1;
                    end
                    // Shift-in keeps the first header byte in the top bits.
                    if (r_byte_cnt < 16'd6) begin
                        r_da_sh <= {r_da_sh[39:0], io_rx_data, r_low};
                    end else if (r_byte_cnt < 16'd12) begin
                        r_sa_sh <= {r_sa_sh[39:0], io_rx_data, r_low};
                    end else if (r_byte_cnt < 16'd14) begin
                        r_et_sh <= {r_et_sh[7:0], io_rx_data, r_low};
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_crc_err   <= 1'b0;
            r_len_err   <= 1'b0;
            r_align_err <= 1'b0;
            r_len       <= '0;
            r_da        <= '0;
            r_sa        <= '0;
            r_etype     <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_END) begin
                r_done      <= 1'b1;
                r_ok        <= w_ok;
                r_crc_err   <= w_crc_err;
                r_len_err   <= w_len_err;
                r_align_err <= w_align_err;
                r_len       <= r_byte_cnt;
                r_da        <= r_da_sh;
                r_sa        <= r_sa_sh;
                r_etype     <= r_et_sh;
            end
        end
    end

    // Clear wins over the increment of a frame ending on the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (io_cnt_clr) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (r_state == S_END) begin
            if (w_ok) begin
                r_good_cnt <= r_good_cnt + 48'd1;
            end else begin
                r_bad_cnt <= r_bad_cnt + 32'd1;
            end
        end
    end

    assign io_byte_valid = r_byte_valid;
    assign io_byte       = r_byte;
    assign io_frame_done = r_done;
    assign io_frame_ok   = r_ok;
    assign io_crc_err    = r_crc_err;
    assign io_len_err    = r_len_err;
    assign io_align_err  = r_align_err;
    assign io_frame_len  = r_len;
    assign io_da         = r_da;
    assign io_sa         = r_sa;
    assign io_etype      = r_etype;
    assign io_good_count = r_good_cnt;
    assign io_bad_count  = r_bad_cnt;

endmodule

// File: tb/tb_eth_mii_frame_rx.sv
// Scoreboard bench for eth_mii_frame_rx: directed frames push expected bytes
// and frame status into queues; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_eth_mii_frame_rx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_ce = 1'b0;
    logic        rx_en = 1'b0;
    logic [3:0]  rx_data = 4'h0;
    logic        cnt_clr = 1'b0;
    logic        byte_valid;
    logic [7:0]  byte_out;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        align_err;
    logic [15:0] frame_len;
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] etype;
    logic [47:0] good_count;
    logic [31:0] bad_count;

    eth_mii_frame_rx dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .io_rx_ce      (rx_ce),
        .io_rx_en      (rx_en),
        .io_rx_data    (rx_data),
        .io_byte_valid (byte_valid),
        .io_byte       (byte_out),
        .io_frame_done (frame_done),
        .io_frame_ok   (frame_ok),
        .io_crc_err    (crc_err),
        .io_len_err    (len_err),
        .io_align_err  (align_err),
        .io_frame_len  (frame_len),
        .io_da         (da),
        .io_sa         (sa),
        .io_etype      (etype),
        .io_cnt_clr    (cnt_clr),
        .io_good_count (good_count),
        .io_bad_count  (bad_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        chk_hdr;
        logic        chk_crc;
        logic        crc_e;
        logic        len_e;
        logic        align_e;
        logic        ok;
        logic [15:0] len;
        logic [47:0] sa;
        logic [47:0] good;
        logic [31:0] bad;
    } exp_t;

    localparam logic [47:0] SA_A = 48'h001122334455;
    localparam logic [47:0] SA_B = 48'h0A0B0C0D0E0F;

    exp_t       exp_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] frm[$];
    exp_t       m_e;
    int         checks = 0;
    int         errors = 0;
    int         stride = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic ce, input logic le, input logic ae,
                                input logic [15:0] len, input logic [47:0] s,
                                input logic [47:0] good, input logic [31:0] bad,
                                input logic hdr, input logic crc_chk);
        exp_t e;
        e.chk_hdr = hdr;
        e.chk_crc = crc_chk;
        e.crc_e   = ce;
        e.len_e   = le;
        e.align_e = ae;
        e.ok      = !(ce || le || ae);
        e.len     = len;
        e.sa      = s;
        e.good    = good;
        e.bad     = bad;
        return e;
    endfunction

    // Frame: broadcast DA, given SA, EtherType 0x0800, counting payload, FCS appended.
    task automatic build(input int total, input logic [47:0] s);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(8'hFF);
        for (int i = 0; i < 6; i++) frm.push_back(s[47-8*i -: 8]);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        while (frm.size() < total - 4) frm.push_back(8'(frm.size()));
        c = 32'hFFFFFFFF;
        for (int i = 0; i < frm.size(); i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic put_nib(input logic e, input logic [3:0] n);
        rx_en   = e;
        rx_data = n;
        rx_ce   = 1'b1;
        @(negedge clock);
        rx_ce = 1'b0;
        repeat (stride - 1) @(negedge clock);
    endtask

    task automatic send(input int npre, input logic extra, input int abort_at, input logic clr);
        for (int i = 0; i < npre; i++) put_nib(1'b1, 4'h5);
        put_nib(1'b1, 4'hD);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == abort_at) begin
                repeat (4) @(negedge clock);
                reset_n = 1'b0;
                rx_en   = 1'b0;
                repeat (3) @(negedge clock);
                reset_n = 1'b1;
                @(negedge clock);
                return;
            end
            if (npre >= 8) exp_bytes.push_back(frm[i]);
            put_nib(1'b1, frm[i][3:0]);
            put_nib(1'b1, frm[i][7:4]);
        end
        if (extra) put_nib(1'b1, 4'hA);
        rx_en   = 1'b0;
        rx_data = 4'h0;
        rx_ce   = 1'b1;
        @(negedge clock);
        rx_ce = 1'b0;
        if (clr) begin
            cnt_clr = 1'b1;
            @(negedge clock);
            cnt_clr = 1'b0;
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " good_count"}, good_count, 0);
        chk({tag, " bad_count"}, bad_count, 0);
        chk({tag, " frame_ok"}, frame_ok, 0);
        chk({tag, " frame_len"}, frame_len, 0);
        chk({tag, " da"}, da, 0);
        chk({tag, " done"}, frame_done, 0);
        chk({tag, " byte_valid"}, byte_valid, 0);
    endtask

    always @(negedge clock) begin
        if (byte_valid) begin
            if (exp_bytes.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte: unexpected byte %0h, none expected", byte_out);
            end else begin
                chk("byte", byte_out, exp_bytes.pop_front());
            end
        end
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done: unexpected frame_done pulse, none expected");
            end else begin
                m_e = exp_q.pop_front();
                if (m_e.chk_crc) chk("crc_err", crc_err, m_e.crc_e);
                chk("len_err", len_err, m_e.len_e);
                chk("align_err", align_err, m_e.align_e);
                chk("frame_ok", frame_ok, m_e.ok);
                chk("frame_len", frame_len, m_e.len);
                if (m_e.chk_hdr) begin
                    chk("da", da, 48'hFFFFFFFFFFFF);
                    chk("sa", sa, m_e.sa);
                    chk("etype", etype, 16'h0800);
                end
                chk("good_count", good_count, m_e.good);
                chk("bad_count", bad_count, m_e.bad);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clock);

        stride = 1;
        build(64, SA_A);
        exp_q.push_back(mk(0, 0, 0, 16'd64, SA_A, 48'd1, 32'd0, 1, 1));
        send(8, 0, -1, 0);

        stride = 8;
        build(64, SA_A);
        frm[20] = frm[20] ^ 8'h01;
        exp_q.push_back(mk(1, 0, 0, 16'd64, SA_A, 48'd1, 32'd1, 1, 1));
        send(8, 0, -1, 0);

        stride = 1;
        build(60, SA_A);
        exp_q.push_back(mk(0, 1, 0, 16'd60, SA_A, 48'd1, 32'd2, 1, 1));
        send(8, 0, -1, 0);

        build(1519, SA_B);
        exp_q.push_back(mk(0, 1, 0, 16'd1519, SA_B, 48'd1, 32'd3, 1, 1));
        send(8, 0, -1, 0);

        stride = 2;
        build(64, SA_A);
        exp_q.push_back(mk(0, 0, 1, 16'd64, SA_A, 48'd1, 32'd4, 1, 0));
        send(8, 1, -1, 0);

        stride = 1;
        build(64, SA_A);
        send(7, 0, -1, 0);
        chk("drop good_count", good_count, 48'd1);
        chk("drop bad_count", bad_count, 32'd4);
        chk("drop no pending", exp_q.size(), 0);

        build(64, SA_B);
        exp_q.push_back(mk(0, 0, 0, 16'd64, SA_B, 48'd2, 32'd4, 1, 1));
        send(8, 0, -1, 0);

        frm.delete();
        exp_q.push_back(mk(1, 1, 0, 16'd0, SA_A, 48'd2, 32'd5, 0, 1));
        send(8, 0, -1, 0);

        stride = 8;
        build(64, SA_A);
        send(8, 0, 30, 0);
        chk_reset_state("midframe reset");
        chk("reset pending bytes", exp_bytes.size(), 0);

        stride = 1;
        build(64, SA_A);
        exp_q.push_back(mk(0, 0, 0, 16'd64, SA_A, 48'd1, 32'd0, 1, 1));
        send(8, 0, -1, 0);

        build(70, SA_B);
        exp_q.push_back(mk(0, 0, 0, 16'd70, SA_B, 48'd0, 32'd0, 1, 1));
        send(9, 0, -1, 1);

        build(64, SA_A);
        exp_q.push_back(mk(0, 0, 0, 16'd64, SA_A, 48'd1, 32'd0, 1, 1));
        send(15, 0, -1, 0);

        repeat (20) @(negedge clock);
        chk("pending frames", exp_q.size(), 0);
        chk("pending bytes", exp_bytes.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
